// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, MSB first (big-endian).
// Optional running byte checksum enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned COUNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [63:0]        i_base_addr,
  input  logic [COUNT_W-1:0] i_word_count,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [31:0]        i_in_word,
  output logic               o_mem_we,
  output logic [63:0]        o_mem_waddr,
  output logic [7:0]         o_mem_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [COUNT_W-1:0] o_words_written,
  output logic [7:0]         o_checksum
);

  localparam logic [63:0] LastAddr = 64'(MEM_BYTES) - 64'd1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitWord,
    StWrite,
    StDone
  } state_e;

  state_e             r_state, w_state_next;
  logic [63:0]        r_cur_addr, w_cur_addr_next;
  logic [COUNT_W-1:0] r_word_count, w_word_count_next;
  logic [COUNT_W-1:0] r_words_written, w_words_written_next;
  logic [31:0]        r_word, w_word_next;
  logic [1:0]         r_byte_idx, w_byte_idx_next;
  logic               r_error, w_error_next;
  logic [63:0]        r_mem_waddr, w_mem_waddr_next;
  logic [7:0]         r_mem_wdata, w_mem_wdata_next;

  logic [63:0]        w_last_addr;
  logic [1:0]         w_idx_inc;
  logic [COUNT_W-1:0] w_written_inc;
  logic [7:0]         w_next_byte;

  assign w_last_addr   = r_cur_addr + 64'd3;
  assign w_idx_inc     = r_byte_idx + 2'd1;
  assign w_written_inc = r_words_written + {{(COUNT_W-1){1'b0}}, 1'b1};
  // Byte i of the word sits at bit 31-8i; {~i, 3'b111} is exactly that index.
  assign w_next_byte   = r_word[{~w_idx_inc, 3'b111} -: 8];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= StIdle;
      r_cur_addr      <= '0;
      r_word_count    <= '0;
      r_words_written <= '0;
      r_word          <= '0;
      r_byte_idx      <= '0;
      r_error         <= 1'b0;
      r_mem_waddr     <= '0;
      r_mem_wdata     <= '0;
    end else begin
      r_state         <= w_state_next;
      r_cur_addr      <= w_cur_addr_next;
      r_word_count    <= w_word_count_next;
      r_words_written <= w_words_written_next;
      r_word          <= w_word_next;
      r_byte_idx      <= w_byte_idx_next;
      r_error         <= w_error_next;
      r_mem_waddr     <= w_mem_waddr_next;
      r_mem_wdata     <= w_mem_wdata_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_cur_addr_next      = r_cur_addr;
    w_word_count_next    = r_word_count;
    w_words_written_next = r_words_written;
    w_word_next          = r_word;
    w_byte_idx_next      = r_byte_idx;
    w_error_next         = r_error;
    w_mem_waddr_next     = r_mem_waddr;
    w_mem_wdata_next     = r_mem_wdata;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_cur_addr_next      = i_base_addr;
          w_word_count_next    = i_word_count;
          w_words_written_next = '0;
          w_error_next         = 1'b0;
          if (i_base_addr[1:0] != 2'b00) begin
            w_error_next = 1'b1;
          end else if (i_word_count == '0) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StWaitWord;
          end
        end
      end
      StWaitWord: begin
        if (i_in_valid) begin
          // Range check before any byte of the word is written.
          if (w_last_addr > LastAddr) begin
            w_error_next = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_word_next      = i_in_word;
            w_byte_idx_next  = 2'd0;
            w_mem_waddr_next = r_cur_addr;
            w_mem_wdata_next = i_in_word[31:24];
            w_state_next     = StWrite;
          end
        end
      end
      StWrite: begin
        if (r_byte_idx == 2'd3) begin
          w_cur_addr_next      = r_cur_addr + 64'd4;
          w_words_written_next = w_written_inc;
          w_state_next         = (w_written_inc == r_word_count) ? StDone : StWaitWord;
        end else begin
          w_byte_idx_next  = w_idx_inc;
          w_mem_waddr_next = r_cur_addr + {62'd0, w_idx_inc};
          w_mem_wdata_next = w_next_byte;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign o_in_ready      = (r_state == StWaitWord);
  assign o_mem_we        = (r_state == StWrite);
  assign o_mem_waddr     = r_mem_waddr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_busy          = (r_state != StIdle);
  assign o_done          = (r_state == StDone);
  assign o_error         = r_error;
  assign o_words_written = r_words_written;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_checksum <= '0;
    end else if (r_state == StIdle && i_start) begin
      r_checksum <= '0;
    end else if (r_state == StWrite) begin
      r_checksum <= r_checksum + r_mem_wdata;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 8'd0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised self-checking bench for instr_mem_loader; expected byte writes come from a
// word-level model of the load rules.
module tb_instr_mem_loader;

  localparam int unsigned MemBytes = 256;
  localparam int unsigned CountW   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [63:0]        base_addr;
  logic [CountW-1:0]  word_count;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_word;
  logic               mem_we;
  logic [63:0]        mem_waddr;
  logic [7:0]         mem_wdata;
  logic               busy;
  logic               done;
  logic               error;
  logic [CountW-1:0]  words_written;
  logic [7:0]         checksum;

  int n_checks = 0;
  int n_errors = 0;

  instr_mem_loader #(
    .MEM_BYTES(MemBytes),
    .COUNT_W  (CountW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_base_addr    (base_addr),
    .i_word_count   (word_count),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_word      (in_word),
    .o_mem_we       (mem_we),
    .o_mem_waddr    (mem_waddr),
    .o_mem_wdata    (mem_wdata),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_words_written(words_written),
    .o_checksum     (checksum)
  );

  always #5 clk = ~clk;

  // Observed memory traffic, sampled mid-cycle.
  logic [63:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          n_done;
  bit          ready_seen;
  logic [7:0]  mem[MemBytes];

  always @(negedge clk) begin
    if (mem_we) begin
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_wdata);
      if (mem_waddr < 64'(MemBytes)) mem[mem_waddr[7:0]] = mem_wdata;
    end
    if (done) n_done++;
    if (in_ready) ready_seen = 1'b1;
  end

  // Reference model: what a load should produce, derived word by word.
  logic [31:0] stim_words[$];
  logic [63:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  int          exp_written;
  bit          exp_error;
  int          exp_done;
  logic [7:0]  exp_sum;
  bit          timeout;

  task automatic model(input logic [63:0] base, input int count);
    logic [63:0] a;
    logic [7:0]  b;
    exp_addr.delete();
    exp_data.delete();
    exp_written = 0;
    exp_sum     = 8'd0;
    exp_done    = 0;
    exp_error   = (base % 4) != 0;
    if (!exp_error) begin
      for (int k = 0; k < count; k++) begin
        a = base + 64'(4 * k);
        if (a + 3 >= 64'(MemBytes)) begin
          exp_error = 1'b1;
          break;
        end
        for (int i = 0; i < 4; i++) begin
          b = 8'((stim_words[k] >> (24 - 8 * i)) & 32'hFF);
          exp_addr.push_back(a + 64'(i));
          exp_data.push_back(b);
          exp_sum = exp_sum + b;
        end
        exp_written++;
      end
      if (!exp_error) exp_done = 1;
    end
`ifndef LOADER_CHECKSUM_EN
    exp_sum = 8'd0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    n_done     = 0;
    ready_seen = 1'b0;
    timeout    = 1'b0;
  endtask

  // Drives one load from stim_words; gap idle cycles before each word, optional start spam.
  task automatic run_load(input logic [63:0] base, input int count, input int gap, input bit spam);
    int bound;
    base_addr  = base;
    word_count = CountW'(count);
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < stim_words.size(); k++) begin
      for (int g = 0; g < gap; g++) begin
        start = spam && busy;
        tick();
        start = 1'b0;
      end
      if (!busy) break;
      in_valid = 1'b1;
      in_word  = stim_words[k];
      bound    = 0;
      while (!in_ready && busy && bound < 50) begin
        start = spam && busy;
        tick();
        start = 1'b0;
        bound++;
      end
      if (bound >= 50) timeout = 1'b1;
      if (!in_ready) begin
        in_valid = 1'b0;
        break;
      end
      tick();
      in_valid = 1'b0;
    end
    in_valid = 1'b0;
    bound    = 0;
    while (busy && bound < 100) begin
      start = spam;
      tick();
      start = 1'b0;
      bound++;
    end
    if (bound >= 100) timeout = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({in_ready, mem_we, busy, done, error} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b want 00000", {in_ready, mem_we, busy, done, error});
    end
    n_checks++;
    if ({mem_waddr, mem_wdata} !== 72'd0) begin
      n_errors++;
      $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_waddr, mem_wdata);
    end
    n_checks++;
    if ({words_written, checksum} !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_counts: got %h/%h want 0/0", words_written, checksum);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_logs();
    stim_words = '{32'h00500093, 32'h00A00113};
    model(64'd0, 2);
    run_load(64'd0, 2, 0, 1'b0);
    n_checks++;
    if (timeout || log_addr.size() != exp_addr.size()) begin
      n_errors++;
      $display("FAIL basic_len: got %0d writes (timeout %0d) want %0d",
               log_addr.size(), timeout, exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      n_checks++;
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
        n_errors++;
        $display("FAIL basic_byte%0d: got (%0d,%h) want (%0d,%h)", i, log_addr[i], log_data[i],
                 exp_addr[i], exp_data[i]);
      end
    end
    n_checks++;
    if (n_done !== exp_done || words_written !== CountW'(exp_written) || error !== exp_error) begin
      n_errors++;
      $display("FAIL basic_status: got done=%0d ww=%0d err=%0d want %0d/%0d/%0d", n_done,
               words_written, error, exp_done, exp_written, exp_error);
    end
    n_checks++;
    if (checksum !== exp_sum) begin
      n_errors++;
      $display("FAIL basic_checksum: got %h want %h", checksum, exp_sum);
    end
  endtask

  task automatic test_count_zero();
    clear_logs();
    base_addr  = 64'd0;
    word_count = '0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_done: got done=%b busy=%b want 1/1", done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_after: got done=%b busy=%b err=%b want 0/0/0", done, busy, error);
    end
    n_checks++;
    if (log_addr.size() != 0 || ready_seen) begin
      n_errors++;
      $display("FAIL zero_idle: got %0d writes ready_seen=%0d want 0/0", log_addr.size(),
               ready_seen);
    end
  endtask

  task automatic test_range_error();
    clear_logs();
    stim_words = '{32'hCAFEF00D, 32'h12345678};
    model(64'd252, 2);
    run_load(64'd252, 2, 0, 1'b0);
    n_checks++;
    if (timeout || log_addr.size() != exp_addr.size()) begin
      n_errors++;
      $display("FAIL range_len: got %0d writes want %0d", log_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      n_checks++;
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
        n_errors++;
        $display("FAIL range_byte%0d: got (%0d,%h) want (%0d,%h)", i, log_addr[i], log_data[i],
                 exp_addr[i], exp_data[i]);
      end
    end
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || n_done != 0 || words_written !== 8'd1) begin
      n_errors++;
      $display("FAIL range_status: got err=%b busy=%b done=%0d ww=%0d want 1/0/0/1", error,
               busy, n_done, words_written);
    end
  endtask

  task automatic test_misaligned();
    clear_logs();
    base_addr  = 64'd2;
    word_count = 8'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL misaligned_err: got err=%b busy=%b want 1/0", error, busy);
    end
    tick();
    tick();
    n_checks++;
    if (ready_seen || log_addr.size() != 0) begin
      n_errors++;
      $display("FAIL misaligned_quiet: got ready=%0d writes=%0d want 0/0", ready_seen,
               log_addr.size());
    end
    base_addr  = 64'd0;
    word_count = '0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (error !== 1'b0) begin
      n_errors++;
      $display("FAIL misaligned_clear: got err=%b want 0", error);
    end
    tick();
  endtask

  task automatic test_gaps();
    clear_logs();
    stim_words = '{32'h00500093, 32'h00A00113};
    model(64'd0, 2);
    run_load(64'd0, 2, 3, 1'b1);
    n_checks++;
    if (timeout || log_addr.size() != exp_addr.size()) begin
      n_errors++;
      $display("FAIL gaps_len: got %0d writes want %0d", log_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      n_checks++;
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
        n_errors++;
        $display("FAIL gaps_byte%0d: got (%0d,%h) want (%0d,%h)", i, log_addr[i], log_data[i],
                 exp_addr[i], exp_data[i]);
      end
    end
    n_checks++;
    if (n_done != 1 || words_written !== 8'd2 || error !== 1'b0 || checksum !== exp_sum) begin
      n_errors++;
      $display("FAIL gaps_status: got done=%0d ww=%0d err=%b cs=%h want 1/2/0/%h", n_done,
               words_written, error, checksum, exp_sum);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 4; i++) mem[i] = 8'hEE;
    clear_logs();
    base_addr  = 64'd0;
    word_count = 8'd1;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || words_written !== 8'd0) begin
      n_errors++;
      $display("FAIL midreset_state: got we=%b busy=%b ww=%0d want 0/0/0", mem_we, busy,
               words_written);
    end
    n_checks++;
    if (log_addr.size() != 2 || mem[0] !== 8'hDE || mem[1] !== 8'hAD || mem[2] !== 8'hEE) begin
      n_errors++;
      $display("FAIL midreset_mem: got n=%0d %h %h %h want 2 de ad ee", log_addr.size(),
               mem[0], mem[1], mem[2]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] base;
    int          count;
    for (int r = 0; r < 8; r++) begin
      clear_logs();
      count = $urandom_range(1, 6);
      base  = 64'(4 * $urandom_range(0, 66));
      if ($urandom_range(0, 5) == 0) base = base + 64'd1;
      stim_words.delete();
      for (int k = 0; k < count; k++) stim_words.push_back($urandom);
      model(base, count);
      run_load(base, count, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      n_checks++;
      if (timeout || log_addr.size() != exp_addr.size()) begin
        n_errors++;
        $display("FAIL rand%0d_len: got %0d writes want %0d", r, log_addr.size(),
                 exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
        n_checks++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
          n_errors++;
          $display("FAIL rand%0d_byte%0d: got (%0d,%h) want (%0d,%h)", r, i, log_addr[i],
                   log_data[i], exp_addr[i], exp_data[i]);
        end
      end
      n_checks++;
      if (n_done != exp_done || words_written !== CountW'(exp_written) ||
          error !== exp_error || checksum !== exp_sum) begin
        n_errors++;
        $display("FAIL rand%0d_status: got done=%0d ww=%0d err=%b cs=%h want %0d/%0d/%0d/%h",
                 r, n_done, words_written, error, checksum, exp_done, exp_written, exp_error,
                 exp_sum);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_word    = '0;
    for (int i = 0; i < MemBytes; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_count_zero();
    test_range_error();
    test_misaligned();
    test_gaps();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart of the byte-wide instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream.
- Writes each word into the 8-bit instruction memory array as four byte writes, MSB first, at ascending byte addresses. This is the same big-endian layout the fetch path reads back.
- Used by the boot/test harness to program the memory before the core leaves reset.

Parameters:
- MEM_BYTES, 256: size of the target byte array. Legal byte addresses are 0..MEM_BYTES-1.
- COUNT_W, 8: width of the word_count and words_written fields.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; sampled in IDLE only
- base_addr  input  64  byte address of the first word; sampled with start
- word_count  input  COUNT_W  number of words to load; sampled with start
- in_valid  input  1  in_word is valid
- in_ready  output  1  loader can accept a word
- in_word  input  32  instruction word; bits [31:24] go to the lowest address
- mem_we  output  1  byte write enable to the instruction memory
- mem_waddr  output  64  byte write address
- mem_wdata  output  8  byte write data
- busy  output  1  load in progress
- done  output  1  one-cycle pulse when a load completes successfully
- error  output  1  sticky fault flag; cleared by reset or by the next accepted start
- words_written  output  COUNT_W  words fully written in the current or most recent load
- checksum  output  8  running byte sum; see Optional Feature

Behaviour:
- Reset values (synchronous, active-high reset): state=IDLE; in_ready, mem_we, busy, done and error all 0; mem_waddr=0, mem_wdata=0, words_written=0, checksum=0.
- A reset mid-load takes effect at that edge: mem_we is 0 in the next cycle. Bytes already written stay in memory.
- States: IDLE, WAIT_WORD, WRITE, DONE.
- IDLE, start=1:
  - Latch base_addr and word_count; clear error, words_written and checksum.
  - If base_addr[1:0]!=0, set error and stay in IDLE. No writes occur.
  - Else if word_count==0, go to DONE.
  - Else go to WAIT_WORD.
- WAIT_WORD:
  - in_ready=1 and busy=1.
  - A word is accepted on an edge where in_valid&&in_ready. The word is latched, byte index is set to 0, and the state moves to WRITE.
  - Range check at acceptance: if cur_addr+3 > MEM_BYTES-1, set error, go to IDLE and write nothing for that word.
- WRITE:
  - in_ready=0, busy=1, mem_we=1 for exactly 4 consecutive cycles.
  - On byte index i: mem_waddr=cur_addr+i and mem_wdata=word[31-8i -: 8].
  - After byte 3: cur_addr+=4 and words_written+=1. If words_written equals word_count, go to DONE; otherwise go to WAIT_WORD.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Latency:
  - First byte write occurs in the cycle after acceptance.
  - Peak throughput is 1 word per 5 cycles (1 accept cycle + 4 write cycles).
  - With word_count=0, done is high in the cycle after start.
- start is ignored while busy.
- mem_we is 0 in every state except WRITE. mem_waddr and mem_wdata hold their last values when mem_we=0.
- Address arithmetic is 64-bit unsigned. cur_addr+3 wrap-around cannot occur because the range check is applied first.
- busy is 0 only in IDLE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined: checksum accumulates (checksum + mem_wdata) mod 256 on every mem_we cycle. It is cleared on reset and on an accepted start, and holds its value after done or error.
- When undefined: checksum is constant 0, with no accumulator logic.

Test Plan:
- Load base=0, count=2, words 0x00500093 then 0x00A00113 -> writes (0,0x00),(1,0x50),(2,0x00),(3,0x93),(4,0x00),(5,0xA0),(6,0x01),(7,0x13); done pulses once; words_written=2; error=0; checksum=0x97 with macro, 0 without.
- start with count=0 -> done=1 one cycle after start; mem_we never asserted; in_ready never asserted.
- base=252, count=2 -> first word written at 252..255; second accepted word sets error=1, no write, busy=0, done never pulses, words_written=1.
- base=2, count=1 -> error=1 the cycle after start; in_ready and mem_we stay 0; a following start with base=0 clears error.
- in_valid gaps of 3 cycles between words plus start pulses while busy -> no write while waiting, extra starts ignored, byte sequence identical to case 1.
- reset asserted after 2 bytes of a word -> next cycle mem_we=0, busy=0, words_written=0; bytes 0..1 remain written in memory.
